// File: rtl/mem_req_arbiter_pkg.sv
// Shared encodings for the IF/MEM memory-port arbiter: FSM states, owner tags
// and the request field bundle forwarded to the memory port.
package mem_req_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    typedef struct packed {
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_fields_t;

    localparam mem_fields_t MEM_FIELDS_NONE = '0;

    // Fetches are always reads, so only the address travels to the port.
    function automatic mem_fields_t inst_fields(input logic [31:0] addr);
        mem_fields_t f;
        f       = MEM_FIELDS_NONE;
        f.addr  = addr;
        return f;
    endfunction

    function automatic mem_fields_t data_fields(
        input logic        wr,
        input logic [3:0]  wstrb,
        input logic [31:0] addr,
        input logic [31:0] wdata
    );
        mem_fields_t f;
        f.wr    = wr;
        f.wstrb = wstrb;
        f.addr  = addr;
        f.wdata = wdata;
        return f;
    endfunction

endpackage

// File: rtl/mem_req_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and load/store,
// data side first, with a starvation guard that periodically forces a fetch.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    // Consecutive data wins only count while a fetch is actually waiting.
    function automatic logic [CNT_W-1:0] starve_next(
        input logic [CNT_W-1:0] cnt,
        input logic             data_win,
        input logic             inst_pending
    );
        if (data_win && inst_pending)
            return (cnt == STARVE_LIM) ? cnt : cnt + CNT_W'(1);
        return '0;
    endfunction

    arb_state_t       state;
    owner_t           owner;
    logic [CNT_W-1:0] starve_cnt;

    logic        in_idle;
    logic        grant_inst;
    logic        grant_data;
    logic        grant_valid;
    logic        accept;
    logic        resp;
    mem_fields_t fields;

    // Gating with resetn keeps every output quiet during the reset cycle.
    assign in_idle     = resetn && (state == ARB_IDLE);
    assign grant_inst  = in_idle && inst_req && (!data_req || (starve_cnt == STARVE_LIM));
    assign grant_data  = in_idle && data_req && !grant_inst;
    assign grant_valid = grant_inst || grant_data;
    assign accept      = grant_valid && mem_addr_ok;

    always_comb begin
        fields = MEM_FIELDS_NONE;
        if (grant_inst)
            fields = inst_fields(inst_addr);
        else if (grant_data)
            fields = data_fields(data_wr, data_wstrb, data_addr, data_wdata);
    end

    assign mem_req   = grant_valid;
    assign mem_wr    = fields.wr;
    assign mem_wstrb = fields.wstrb;
    assign mem_addr  = fields.addr;
    assign mem_wdata = fields.wdata;

    assign inst_addr_ok = grant_inst && mem_addr_ok;
    assign data_addr_ok = grant_data && mem_addr_ok;

    // A response is only meaningful while a transaction is outstanding.
    assign resp         = resetn && (state == ARB_WAIT) && mem_data_ok;
    assign inst_data_ok = resp && (owner == OWN_INST);
    assign data_data_ok = resp && (owner == OWN_DATA);
    assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
    assign data_rdata   = data_data_ok ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= ARB_IDLE;
            owner      <= OWN_INST;
            starve_cnt <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (accept) begin
                        state      <= ARB_WAIT;
                        owner      <= grant_data ? OWN_DATA : OWN_INST;
                        starve_cnt <= starve_next(starve_cnt, grant_data, inst_req);
                    end
                end
                ARB_WAIT: begin
                    if (mem_data_ok)
                        state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: stimulus queues expected grants and
// responses, a negedge monitor pops and compares whenever the DUT presents one.
module tb_mem_req_arbiter;

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    mem_req_arbiter #(.STARVE_MAX(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    typedef struct {
        logic        is_data;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_exp_t;

    typedef struct {
        logic        is_data;
        logic [31:0] rdata;
    } rsp_exp_t;

    req_exp_t req_q[$];
    rsp_exp_t rsp_q[$];
    req_exp_t mon_req;
    rsp_exp_t mon_rsp;

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic flag(input string name, input logic [127:0] got);
        total++;
        bad++;
        $display("FAIL %s got=%0h exp=none", name, got);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue the expected grant and let the port accept for one cycle.
    task automatic accept(input logic is_data, input logic wr, input logic [3:0] wstrb,
                          input logic [31:0] addr, input logic [31:0] wdata);
        req_exp_t e;
        e.is_data = is_data;
        e.wr      = wr;
        e.wstrb   = wstrb;
        e.addr    = addr;
        e.wdata   = wdata;
        req_q.push_back(e);
        mem_addr_ok = 1'b1;
        step();
        mem_addr_ok = 1'b0;
    endtask

    task automatic respond(input logic is_data, input logic [31:0] rdata);
        rsp_exp_t r;
        r.is_data = is_data;
        r.rdata   = rdata;
        rsp_q.push_back(r);
        mem_data_ok = 1'b1;
        mem_rdata   = rdata;
        step();
        mem_data_ok = 1'b0;
        mem_rdata   = '0;
    endtask

    always @(negedge clk) begin
        if (mem_req && mem_addr_ok) begin
            if (req_q.size() == 0) begin
                flag("unexpected_grant", 128'(mem_addr));
            end else begin
                mon_req = req_q.pop_front();
                check("grant",
                      128'({data_addr_ok, inst_addr_ok, mem_wr, mem_wstrb, mem_addr, mem_wdata}),
                      128'({mon_req.is_data, !mon_req.is_data, mon_req.wr, mon_req.wstrb,
                            mon_req.addr, mon_req.wdata}));
            end
        end else if (inst_addr_ok || data_addr_ok) begin
            flag("stray_addr_ok", 128'({inst_addr_ok, data_addr_ok}));
        end

        if (inst_data_ok || data_data_ok) begin
            if (rsp_q.size() == 0) begin
                flag("unexpected_data_ok", 128'({inst_data_ok, data_data_ok, inst_rdata, data_rdata}));
            end else begin
                mon_rsp = rsp_q.pop_front();
                check("response",
                      128'({data_data_ok, inst_data_ok, inst_rdata, data_rdata}),
                      128'({mon_rsp.is_data, !mon_rsp.is_data,
                            mon_rsp.is_data ? 32'h0 : mon_rsp.rdata,
                            mon_rsp.is_data ? mon_rsp.rdata : 32'h0}));
            end
        end else if ((inst_rdata != 32'h0) || (data_rdata != 32'h0)) begin
            flag("rdata_leak", 128'({inst_rdata, data_rdata}));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    logic starve_pat [10];

    initial begin
        starve_pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset with every input asserted: outputs must stay at zero.
        resetn      = 1'b0;
        inst_req    = 1'b1;
        inst_addr   = 32'h1c000000;
        data_req    = 1'b1;
        data_wr     = 1'b1;
        data_wstrb  = 4'hF;
        data_addr   = 32'h8;
        data_wdata  = 32'h11223344;
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hFFFFFFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset_outputs",
                  128'({mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata, inst_addr_ok,
                        data_addr_ok, inst_data_ok, data_data_ok}), 128'h0);
            check("reset_rdata", 128'({inst_rdata, data_rdata}), 128'h0);
        end
        step();
        resetn      = 1'b1;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_wstrb  = 4'h0;
        data_wdata  = 32'h0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;

        // Single fetch: accept on cycle 1, response on cycle 3.
        accept(1'b0, 1'b0, 4'h0, 32'h1c000000, 32'h0);
        inst_req = 1'b0;
        @(negedge clk);
        check("fetch_wait_quiet", 128'({mem_req, inst_addr_ok, inst_data_ok, data_data_ok}), 128'h0);
        step();
        respond(1'b0, 32'h02800421);

        // Simultaneous requests: the load wins, the fetch follows after its response.
        inst_req  = 1'b1;
        inst_addr = 32'h1c000004;
        data_req  = 1'b1;
        data_addr = 32'h8;
        accept(1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
        data_req    = 1'b0;
        mem_addr_ok = 1'b1;
        @(negedge clk);
        check("wait_blocks_fetch", 128'({mem_req, inst_addr_ok, data_addr_ok}), 128'h0);
        mem_addr_ok = 1'b0;
        respond(1'b1, 32'h11112222);
        accept(1'b0, 1'b0, 4'h0, 32'h1c000004, 32'h0);
        inst_req = 1'b0;
        respond(1'b0, 32'h33334444);

        // Store: fields forwarded verbatim, single data_ok.
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_wstrb = 4'hF;
        data_addr  = 32'h100;
        data_wdata = 32'hDEADBEEF;
        accept(1'b1, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF);
        data_req = 1'b0;
        respond(1'b1, 32'h0);

        // Starvation: both held high, expected order D D D D I repeating.
        inst_req   = 1'b1;
        inst_addr  = 32'h1c000010;
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_wstrb = 4'h3;
        data_addr  = 32'h40;
        data_wdata = 32'h12345678;
        for (int i = 0; i < 10; i++) begin
            if (starve_pat[i])
                accept(1'b1, 1'b1, 4'h3, 32'h40, 32'h12345678);
            else
                accept(1'b0, 1'b0, 4'h0, 32'h1c000010, 32'h0);
            respond(starve_pat[i], 32'hA0000000 + 32'(i));
        end
        inst_req   = 1'b0;
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_wstrb = 4'h0;
        data_wdata = 32'h0;

        // Stalled port: request and fields held steady, no addr_ok.
        data_req  = 1'b1;
        data_addr = 32'h44;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_hold",
                  128'({mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata, data_addr_ok, inst_addr_ok}),
                  128'({1'b1, 1'b0, 4'h0, 32'h44, 32'h0, 1'b0, 1'b0}));
            step();
        end
        accept(1'b1, 1'b0, 4'h0, 32'h44, 32'h0);
        data_req = 1'b0;
        respond(1'b1, 32'h5A5A5A5A);

        // Reset while a fetch is outstanding: the late response is dropped.
        inst_req  = 1'b1;
        inst_addr = 32'h1c000020;
        accept(1'b0, 1'b0, 4'h0, 32'h1c000020, 32'h0);
        inst_req = 1'b0;
        resetn   = 1'b0;
        step();
        resetn      = 1'b1;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hBAD0BAD0;
        @(negedge clk);
        check("reset_drops_resp", 128'({inst_data_ok, data_data_ok, inst_rdata}), 128'h0);
        step();
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;
        inst_req    = 1'b1;
        inst_addr   = 32'h1c000024;
        accept(1'b0, 1'b0, 4'h0, 32'h1c000024, 32'h0);
        inst_req = 1'b0;
        respond(1'b0, 32'h0BADF00D);

        step();
        check("queues_drained", 128'(req_q.size() + rsp_q.size()), 128'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
